// File: rtl/seg7_reader.sv
// Seven-segment bus reader: synchronizes the segment bus, waits for a stable pattern,
// decodes it back to a hex digit and hands each new word out over valid/ready.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic       ready,
    input  logic       clr_overrun,
    output logic       valid,
    output logic [3:0] digit,
    output logic       dp,
    output logic       blank,
    output logic       invalid,
    output logic       overrun,
    output logic [7:0] change_count
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_TC  = 8'(STABLE_CYCLES - 1);

    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] last_q, last_d;
    logic       valid_q, valid_d;
    logic [3:0] digit_q, digit_d;
    logic       dp_q, dp_d;
    logic       blank_q, blank_d;
    logic       invalid_q, invalid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] change_count_q, change_count_d;

    logic       commit;
    logic       dec_hit;
    logic [3:0] dec_digit;

    // Segment glyph lookup on a-g only; dec_hit is low for anything that is not a hex glyph.
    always_comb begin
        dec_hit   = 1'b1;
        dec_digit = 4'h0;
        case (prev_q[6:0])
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    always_comb begin
        s1_d           = seg_in;
        s2_d           = s1_q;
        prev_d         = prev_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        valid_d        = valid_q;
        digit_d        = digit_q;
        dp_d           = dp_q;
        blank_d        = blank_q;
        invalid_d      = invalid_q;
        overrun_d      = overrun_q;
        change_count_d = change_count_q;
        commit         = 1'b0;

        if (s2_q != prev_q) begin
            prev_d = s2_q;
            cnt_d  = 8'd0;
        end else begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            // Saturation means cnt only passes through CNT_TC once per stable run.
            if ((cnt_q == CNT_TC) && (prev_q != last_q)) begin
                commit = 1'b1;
            end
        end

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        if (commit) begin
            last_d         = prev_q;
            valid_d        = 1'b1;
            dp_d           = prev_q[7];
            blank_d        = (prev_q[6:0] == 7'h00);
            invalid_d      = !dec_hit && (prev_q[6:0] != 7'h00);
            digit_d        = dec_hit ? dec_digit : 4'h0;
            change_count_d = change_count_q + 8'd1;
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= 8'h00;
            s2_q           <= 8'h00;
            prev_q         <= 8'h00;
            cnt_q          <= 8'd0;
            last_q         <= 8'h00;
            valid_q        <= 1'b0;
            digit_q        <= 4'h0;
            dp_q           <= 1'b0;
            blank_q        <= 1'b1;
            invalid_q      <= 1'b0;
            overrun_q      <= 1'b0;
            change_count_q <= 8'd0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            valid_q        <= valid_d;
            digit_q        <= digit_d;
            dp_q           <= dp_d;
            blank_q        <= blank_d;
            invalid_q      <= invalid_d;
            overrun_q      <= overrun_d;
            change_count_q <= change_count_d;
        end
    end

    assign valid        = valid_q;
    assign digit        = digit_q;
    assign dp           = dp_q;
    assign blank        = blank_q;
    assign invalid      = invalid_q;
    assign overrun      = overrun_q;
    assign change_count = change_count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: default instance plus a STABLE_CYCLES=1 instance on the same bus.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_in;
    logic       ready;
    logic       clr_overrun;

    logic       valid, dp, blank, invalid, overrun;
    logic [3:0] digit;
    logic [7:0] change_count;

    logic       valid1, dp1, blank1, invalid1, overrun1;
    logic [3:0] digit1;
    logic [7:0] change_count1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .ready(ready), .clr_overrun(clr_overrun),
        .valid(valid), .digit(digit), .dp(dp), .blank(blank), .invalid(invalid),
        .overrun(overrun), .change_count(change_count)
    );

    seg7_reader #(.STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .ready(ready), .clr_overrun(clr_overrun),
        .valid(valid1), .digit(digit1), .dp(dp1), .blank(blank1), .invalid(invalid1),
        .overrun(overrun1), .change_count(change_count1)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; seg_in = 8'h00; ready = 1'b0; clr_overrun = 1'b0;
        tick(3);
        rst = 1'b0;
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid); end
        tests_run++; if (digit !== 4'h0) begin tests_failed++; $display("FAIL reset_digit got %h want 0", digit); end
        tests_run++; if (dp !== 1'b0) begin tests_failed++; $display("FAIL reset_dp got %b want 0", dp); end
        tests_run++; if (blank !== 1'b1) begin tests_failed++; $display("FAIL reset_blank got %b want 1", blank); end
        tests_run++; if (invalid !== 1'b0) begin tests_failed++; $display("FAIL reset_invalid got %b want 0", invalid); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
        tests_run++; if (change_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", change_count); end
        tick(20);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL zero_hold_valid got %b want 0", valid); end
        tests_run++; if (blank !== 1'b1) begin tests_failed++; $display("FAIL zero_hold_blank got %b want 1", blank); end
        tests_run++; if (change_count !== 8'd0) begin tests_failed++; $display("FAIL zero_hold_count got %0d want 0", change_count); end
    endtask

    task automatic test_first_commit();
        seg_in = 8'h5B; ready = 1'b1;
        tick(3);
        tests_run++; if (valid1 !== 1'b0) begin tests_failed++; $display("FAIL sc1_early_valid got %b want 0", valid1); end
        tick(1);
        tests_run++; if (valid1 !== 1'b1) begin tests_failed++; $display("FAIL sc1_e4_valid got %b want 1", valid1); end
        tests_run++; if (digit1 !== 4'h2) begin tests_failed++; $display("FAIL sc1_e4_digit got %h want 2", digit1); end
        tick(2);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL e6_valid got %b want 0", valid); end
        tick(1);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL e7_valid got %b want 1", valid); end
        tests_run++; if (digit !== 4'h2) begin tests_failed++; $display("FAIL e7_digit got %h want 2", digit); end
        tests_run++; if (change_count !== 8'd1) begin tests_failed++; $display("FAIL e7_count got %0d want 1", change_count); end
        tests_run++; if (blank !== 1'b0) begin tests_failed++; $display("FAIL e7_blank got %b want 0", blank); end
        tick(1);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL accept_valid got %b want 0", valid); end
        tests_run++; if (digit !== 4'h2) begin tests_failed++; $display("FAIL accept_digit_hold got %h want 2", digit); end
    endtask

    task automatic test_glitch();
        seg_in = 8'h06;
        tick(7);
        tests_run++; if (digit !== 4'h1) begin tests_failed++; $display("FAIL glitch_base_digit got %h want 1", digit); end
        tests_run++; if (change_count !== 8'd2) begin tests_failed++; $display("FAIL glitch_base_count got %0d want 2", change_count); end
        tick(3);
        seg_in = 8'h4F;
        tick(4);
        seg_in = 8'h06;
        tick(12);
        tests_run++; if (change_count !== 8'd2) begin tests_failed++; $display("FAIL glitch_count got %0d want 2", change_count); end
        tests_run++; if (digit !== 4'h1) begin tests_failed++; $display("FAIL glitch_digit got %h want 1", digit); end
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid got %b want 0", valid); end
    endtask

    task automatic test_dp_invalid();
        seg_in = 8'h86;
        tick(7);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL dp_valid got %b want 1", valid); end
        tests_run++; if (digit !== 4'h1) begin tests_failed++; $display("FAIL dp_digit got %h want 1", digit); end
        tests_run++; if (dp !== 1'b1) begin tests_failed++; $display("FAIL dp_flag got %b want 1", dp); end
        tests_run++; if (change_count !== 8'd3) begin tests_failed++; $display("FAIL dp_count got %0d want 3", change_count); end
        tick(1);
        seg_in = 8'h49;
        tick(7);
        tests_run++; if (invalid !== 1'b1) begin tests_failed++; $display("FAIL inv_flag got %b want 1", invalid); end
        tests_run++; if (digit !== 4'h0) begin tests_failed++; $display("FAIL inv_digit got %h want 0", digit); end
        tests_run++; if (blank !== 1'b0) begin tests_failed++; $display("FAIL inv_blank got %b want 0", blank); end
        tests_run++; if (dp !== 1'b0) begin tests_failed++; $display("FAIL inv_dp got %b want 0", dp); end
        tests_run++; if (change_count !== 8'd4) begin tests_failed++; $display("FAIL inv_count got %0d want 4", change_count); end
        tick(1);
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        seg_in = 8'h3F;
        tick(7);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_first_valid got %b want 1", valid); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_first_flag got %b want 0", overrun); end
        seg_in = 8'h7F;
        tick(7);
        tests_run++; if (digit !== 4'h8) begin tests_failed++; $display("FAIL ovr_digit got %h want 8", digit); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b want 1", overrun); end
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid got %b want 1", valid); end
        tests_run++; if (change_count !== 8'd6) begin tests_failed++; $display("FAIL ovr_count got %0d want 6", change_count); end
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b want 0", overrun); end
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_clear_valid got %b want 1", valid); end
        ready = 1'b1;
        tick(1);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_accept_valid got %b want 0", valid); end
        ready = 1'b0;
        // Overrun set coinciding with a clear request must leave the flag set.
        seg_in = 8'h66;
        tick(7);
        seg_in = 8'h6D;
        tick(6);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL set_wins got %b want 1", overrun); end
        tests_run++; if (digit !== 4'h5) begin tests_failed++; $display("FAIL set_wins_digit got %h want 5", digit); end
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL set_wins_clear got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        seg_in = 8'h7D;
        tick(6);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_pre_valid got %b want 1", valid); end
        ready = 1'b1;
        tick(1);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid got %b want 1", valid); end
        tests_run++; if (digit !== 4'h6) begin tests_failed++; $display("FAIL b2b_digit got %h want 6", digit); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        tests_run++; if (change_count !== 8'd9) begin tests_failed++; $display("FAIL b2b_count got %0d want 9", change_count); end
        tick(1);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept got %b want 0", valid); end
    endtask

    task automatic test_all_glyphs();
        logic [7:0] pats [16];
        pats = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            seg_in = pats[k];
            tick(7);
            tests_run++;
            if (valid !== 1'b1 || digit !== 4'(k) || invalid !== 1'b0 || blank !== 1'b0) begin
                tests_failed++;
                $display("FAIL glyph_%0d got valid=%b digit=%h inv=%b blank=%b want 1 %h 0 0",
                         k, valid, digit, invalid, blank, 4'(k));
            end
            tick(1);
        end
        tests_run++; if (change_count !== 8'd25) begin tests_failed++; $display("FAIL glyph_count got %0d want 25", change_count); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; seg_in = 8'h00;
        tick(1);
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            seg_in = i[0] ? 8'h5B : 8'h06;
            tick(7);
            if (i == 254) begin
                tests_run++; if (change_count !== 8'd255) begin tests_failed++; $display("FAIL wrap_255 got %0d want 255", change_count); end
            end
        end
        tests_run++; if (change_count !== 8'd0) begin tests_failed++; $display("FAIL wrap_count got %0d want 0", change_count); end
        tests_run++; if (digit !== 4'h2) begin tests_failed++; $display("FAIL wrap_digit got %h want 2", digit); end
    endtask

    task automatic test_mid_reset();
        ready = 1'b0;
        seg_in = 8'h7D;
        tick(7);
        tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid got %b want 1", valid); end
        seg_in = 8'h79;
        tick(2);
        rst = 1'b1; seg_in = 8'h00;
        tick(1);
        rst = 1'b0;
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b want 0", valid); end
        tests_run++; if (digit !== 4'h0) begin tests_failed++; $display("FAIL mid_digit got %h want 0", digit); end
        tests_run++; if (blank !== 1'b1) begin tests_failed++; $display("FAIL mid_blank got %b want 1", blank); end
        tests_run++; if (invalid !== 1'b0) begin tests_failed++; $display("FAIL mid_invalid got %b want 0", invalid); end
        tests_run++; if (change_count !== 8'd0) begin tests_failed++; $display("FAIL mid_count got %0d want 0", change_count); end
        tick(15);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL mid_zero_valid got %b want 0", valid); end
        tests_run++; if (change_count !== 8'd0) begin tests_failed++; $display("FAIL mid_zero_count got %0d want 0", change_count); end
        tests_run++; if (blank !== 1'b1) begin tests_failed++; $display("FAIL mid_zero_blank got %b want 1", blank); end
    endtask

    initial begin
        test_reset();
        test_first_commit();
        test_glitch();
        test_dp_invalid();
        test_overrun();
        test_back_to_back();
        test_all_glyphs();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Receive-side counterpart of the seven-segment encoder. It samples an 8-bit segment bus (a–g plus decimal point), for example the design's own `uo_out` looped back for self-test or an external display driver. It waits until the pattern is stable, decodes it back to a hex digit, and hands each new digit to a consumer over a valid/ready handshake. It sits beside the display path as a checker and readback block. It also counts committed changes and flags illegal patterns and consumer overruns.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a pattern commits; legal range 1–255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seg_in` in 8: segment bus, active-high; bit0=a … bit6=g, bit7=dp; asynchronous to `clk`.
- `ready` in 1: consumer accepts the current word at an edge where `valid` and `ready` are both high.
- `clr_overrun` in 1: clears the `overrun` flag at the next edge.
- `valid` out 1: a committed word is held and not yet accepted.
- `digit` out 4: decoded hex value.
- `dp` out 1: decimal point of the committed pattern.
- `blank` out 1: committed pattern has a–g all zero.
- `invalid` out 1: committed a–g pattern is neither a hex glyph nor blank.
- `overrun` out 1: sticky; a commit happened while the previous word was unaccepted.
- `change_count` out 8: number of commits, modulo 256.

## Operation
- **Synchronizer.** Two flops, s1 then s2, 8 bits wide. Both reset to 0x00.
- **Stability tracker.**
  - `prev` holds the last s2 value and resets to 0x00.
  - `cnt` is a saturating counter that resets to 0.
  - If s2 ≠ `prev`: `prev`←s2 and `cnt`←0.
  - Otherwise `cnt`←min(`cnt`+1, `STABLE_CYCLES`).
- **Commit.** A commit occurs on the edge where `cnt` steps from `STABLE_CYCLES`−1 to `STABLE_CYCLES`, provided `prev` ≠ `last`.
  - The comparison uses all 8 bits, so a dp-only change also commits.
  - `last` resets to 0x00.
  - On commit, `last`←`prev`, and the output fields are loaded on the same edge.
- **Decode table** (a–g value → digit):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3
  - 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b
  - 0x39→C, 0x5E→d, 0x79→E, 0x71→F
- **Special patterns.**
  - 0x00 gives `blank`=1 and `digit`=0.
  - Any other pattern gives `invalid`=1 and `digit`=0.
  - `blank` and `invalid` are never both 1.
- **Handshake.**
  - Commit: `valid`←1.
  - Edge with `valid`&`ready` and no commit: `valid`←0; the fields hold their values.
  - Commit while `valid`&¬`ready`: the new word overwrites the old one and `overrun`←1.
  - Commit on the same edge as `valid`&`ready`: the old word counts as accepted, the new word loads, `valid` stays 1, and there is no overrun.
- **`overrun`.**
  - Cleared by `rst` or `clr_overrun`.
  - If a set and a clear happen on the same edge, the set wins.
- **`change_count`.** Increments by 1 on every commit and wraps from 255 to 0.

## Timing
- **Reset values:** `valid`=0, `digit`=0, `dp`=0, `blank`=1, `invalid`=0, `overrun`=0, `change_count`=0.
- **Latency.** Suppose a new pattern is present before edge E1 and held. Then:
  - s2 holds it after E2.
  - The `prev` update occurs at E3.
  - The commit occurs at E(3+`STABLE_CYCLES`), which is E7 at the default.
- **Glitches.** A glitch shorter than `STABLE_CYCLES`+1 synchronized samples never commits.
- **Returning patterns.** A pattern that returns to `last` after a glitch does not commit.
- **Saturation.** `cnt` saturates and does not wrap, so a long stable pattern commits exactly once.
- **`STABLE_CYCLES`=1.** The commit occurs at E4.
- **Reset mid-operation.**
  - `rst` high at any edge returns every register to its reset value on that edge and drops any pending word.
  - `seg_in` being 0x00 after reset does not commit.
- **Ready timing.**
  - `ready` is sampled only at edges.
  - `valid` may be asserted combinationally-independent of `ready`; no output depends combinationally on any input.

## Test plan
- **Reset and first commit.** After reset, hold `seg_in`=0x00 for 20 cycles → `valid` stays 0 and `blank`=1. Then apply 0x5B with `ready`=1 → `valid`=1 at E7, `digit`=2, `change_count`=1, and `valid`=0 one edge later.
- **Glitch rejection.** With 0x06 committed, drive 0x4F for 3 cycles, then return to 0x06 → no commit, `change_count` unchanged.
- **dp and invalid.** Drive 0x86 → commit with `digit`=1, `dp`=1. Then drive 0x49 → `invalid`=1, `digit`=0, `blank`=0.
- **Overrun and clear.** With `ready`=0, commit 0x3F then 0x7F → `digit`=8, `overrun`=1, `valid`=1. Pulse `clr_overrun` → `overrun`=0. Raise `ready` → `valid`=0.
- **Simultaneous accept and commit.** Assert `ready` on exactly the commit edge of the next word while `valid`=1 → `valid` stays 1 with the new digit and `overrun` stays 0.
- **Wrap and mid-operation reset.** Run 256 alternating commits → `change_count`=0. Assert `rst` 2 cycles into a stability window → all outputs at reset values, and no commit follows for 0x00.
